// File: rtl/tpu_skew_feeder.sv
// ---------------------------------------------------------------------------------------------
// tpu_skew_feeder
//
// Operand feeder for the left (A) or top (B) edge of the tpumac systolic array. It holds a
// DIM x DIM matrix of signed BITS_AB elements and streams it into the array with diagonal skew.
// Lane i carries row i of the matrix and is delayed by i cycles, so the lane for row i presents
// element mem[i][t-i] at stream time t. Lanes outside their window drive zero. mac_en stays
// high for every stream cycle, and done pulses once after the last one.
//
// Parameters
//   BITS_AB  width of one signed operand element
//   DIM      array dimension: rows, columns and output lanes (DIM >= 2)
//
// Ports
//   clk      clock
//   rst_n    asynchronous active-low reset; clears storage, outputs and the FSM
//   wr_en    write one matrix row (accepted only while idle)
//   wr_row   row index for the write; rows >= DIM are ignored
//   wr_data  row vector, element j at [j*BITS_AB +: BITS_AB]
//   start    begin streaming (accepted only while idle and not writing)
//   a_out    skewed lanes, lane i at [i*BITS_AB +: BITS_AB]
//   mac_en   enable for every tpumac in the array
//   busy     high while streaming
//   done     one-cycle pulse after the last mac_en cycle
//
// All outputs are registered. No input reaches an output combinationally.
// ---------------------------------------------------------------------------------------------
module tpu_skew_feeder #(
    parameter int unsigned BITS_AB = 8,
    parameter int unsigned DIM     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DIM)-1:0]   wr_row,
    input  logic [DIM*BITS_AB-1:0]   wr_data,
    input  logic                     start,
    output logic [DIM*BITS_AB-1:0]   a_out,
    output logic                     mac_en,
    output logic                     busy,
    output logic                     done
);

    // The stream length covers the last non-zero element (t = 2*DIM-2) and then DIM-1 more
    // cycles, so that element can cross the whole array while en is still high.
    localparam int unsigned L  = 3 * DIM - 2;
    localparam int unsigned TW = $clog2(L + 1);
    localparam int unsigned RW = $clog2(DIM);

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

    state_e                    state;
    logic [TW-1:0]             t;
    logic signed [BITS_AB-1:0] mem [DIM][DIM];

    logic                      row_ok;
    logic                      last;
    logic [TW-1:0]             t_sel;
    logic [DIM*BITS_AB-1:0]    lanes;

    // A non-power-of-two DIM leaves row codes that have no storage behind them.
    assign row_ok = (32'(wr_row) < DIM);
    assign last   = (t == TW'(L - 1));

    // Compute the lane values for the stream time that the next edge will show. That is
    // t = 0 when a start is accepted from idle, and t + 1 while streaming. Because of this,
    // the registered a_out lines up with mac_en in the same cycle.
    always_comb begin
        int d;
        d     = 0;
        t_sel = (state == StIdle) ? '0 : t + TW'(1);
        lanes = '0;
        for (int i = 0; i < int'(DIM); i++) begin
            d = int'(t_sel) - i;
            if (d >= 0 && d < int'(DIM)) begin
                lanes[i*BITS_AB +: BITS_AB] = mem[i][d[RW-1:0]];
            end
        end
    end

    // Matrix storage. Writes are accepted only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DIM); i++) begin
                for (int j = 0; j < int'(DIM); j++) begin
                    mem[i][j] <= '0;
                end
            end
        end else if (state == StIdle && wr_en && row_ok) begin
            for (int j = 0; j < int'(DIM); j++) begin
                mem[wr_row][j] <= wr_data[j*BITS_AB +: BITS_AB];
            end
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            t      <= '0;
            a_out  <= '0;
            mac_en <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    a_out  <= '0;
                    mac_en <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    // If a write and a start arrive together, the write wins and the start
                    // is dropped.
                    if (start && !wr_en) begin
                        state  <= StStream;
                        t      <= '0;
                        a_out  <= lanes;
                        mac_en <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                StStream: begin
                    if (last) begin
                        state  <= StDone;
                        a_out  <= '0;
                        mac_en <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        t     <= t + TW'(1);
                        a_out <= lanes;
                    end
                end
                StDone: begin
                    state <= StIdle;
                    t     <= '0;
                    done  <= 1'b0;
                end
                default: begin
                    state  <= StIdle;
                    t      <= '0;
                    a_out  <= '0;
                    mac_en <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule
